// File: rtl/ecc_useq_pkg.sv
// Shared definitions for the ECC microprogram sequencer: opcodes, microword
// layout, FSM states and the default multi-cycle opcode mask.
package ecc_useq_pkg;

  localparam int unsigned WORD_W = 21;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_FADD = 3'b001;
  localparam logic [2:0] OP_LOOP = 3'b010;
  localparam logic [2:0] OP_FMUL = 3'b011;
  localparam logic [2:0] OP_FSUB = 3'b100;
  localparam logic [2:0] OP_FSQR = 3'b101;
  localparam logic [2:0] OP_FINV = 3'b110;
  localparam logic [2:0] OP_FMOV = 3'b111;

  // Opcodes 011 (FMUL) and 110 (FINV) stall until the datapath signals completion.
  localparam logic [7:0] LONG_OP_MASK_DEF = 8'b0100_1000;

  // Microword fields, MSB first: [20:18] op, [17:16] mode, [15:8] fa, [7:0] fb.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] mode;
    logic [7:0] fa;
    logic [7:0] fb;
  } uword_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/ecc_useq_if.sv
// Microcode ROM and datapath command bus between the sequencer (master)
// and the ROM/field-arithmetic datapath (slave).
interface ecc_useq_if;
  logic [7:0]  rom_addr;
  logic [20:0] rom_data;
  logic        dp_valid;
  logic [2:0]  dp_op;
  logic [1:0]  dp_mode;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic        dp_ready;
  logic        dp_done;

  modport master (
    output rom_addr, dp_valid, dp_op, dp_mode, dp_a, dp_b,
    input  rom_data, dp_ready, dp_done
  );

  modport slave (
    input  rom_addr, dp_valid, dp_op, dp_mode, dp_a, dp_b,
    output rom_data, dp_ready, dp_done
  );
endinterface

// File: rtl/ecc_useq_loop.sv
// Hardware loop counter: one non-nesting loop with an iteration count and
// a head address; reports whether LOOP_END jumps back and the bit index.
module ecc_loop_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set,
  input  logic       i_end,
  input  logic [7:0] i_pc,
  input  logic [7:0] i_fa,
  output logic       o_taken,
  output logic [7:0] o_head,
  output logic [7:0] o_bit_idx
);

  logic [7:0] r_cnt;
  logic [7:0] r_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_head <= '0;
    end else if (i_set) begin
      r_cnt  <= i_fa;
      r_head <= i_pc + 8'd1;
    end else if (i_end) begin
      // Count of 0 or 1 falls through, so the body always runs at least once.
      r_cnt <= (r_cnt > 8'd1) ? r_cnt - 8'd1 : '0;
    end
  end

  assign o_taken   = i_end && (r_cnt > 8'd1);
  assign o_head    = r_head;
  assign o_bit_idx = (r_cnt != '0) ? r_cnt - 8'd1 : '0;

endmodule

// File: rtl/ecc_useq.sv
// ECC point-arithmetic microprogram sequencer: fetches and decodes microcode,
// runs hardware loops and issues datapath commands over valid/ready.
module ecc_useq
  import ecc_useq_pkg::*;
#(
  parameter int unsigned PROG_LEN     = 70,
  parameter logic [7:0]  LONG_OP_MASK = LONG_OP_MASK_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  ecc_useq_if.master      bus,
  output logic [7:0]      bit_idx
);

  localparam logic [8:0] LEN9 = 9'(PROG_LEN);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [8:0] w_pc_inc;
  uword_t     w_word;
  logic       w_adv;
  logic       w_set;
  logic       w_end;
  logic       w_taken;
  logic [7:0] w_head;

  assign w_word   = uword_t'(bus.rom_data);
  assign w_pc_inc = {1'b0, r_pc} + 9'd1;

  assign bus.rom_addr = r_pc;
  assign bus.dp_op    = w_word.op;
  assign bus.dp_mode  = w_word.mode;
  assign bus.dp_a     = w_word.fa;
  assign bus.dp_b     = w_word.fb;

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_FIN);

  ecc_loop_ctr u_loop (
    .clk       (clk),
    .rst       (rst),
    .i_set     (w_set),
    .i_end     (w_end),
    .i_pc      (r_pc),
    .i_fa      (w_word.fa),
    .o_taken   (w_taken),
    .o_head    (w_head),
    .o_bit_idx (bit_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_adv        = 1'b0;
    w_set        = 1'b0;
    w_end        = 1'b0;
    bus.dp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = '0;
        end
      end
      ST_RUN: begin
        if (w_word.op == OP_NOP) begin
          w_adv = 1'b1;
        end else if (w_word.op == OP_LOOP) begin
          if (w_word.fb != '0) begin
            w_set = 1'b1;
            w_adv = 1'b1;
          end else begin
            w_end = 1'b1;
            if (w_taken) w_pc_nxt = w_head;
            else         w_adv    = 1'b1;
          end
        end else begin
          bus.dp_valid = 1'b1;
          if (bus.dp_ready) begin
            if (LONG_OP_MASK[w_word.op]) w_state_nxt = ST_WAIT;
            else                         w_adv       = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.dp_done) w_adv = 1'b1;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Advancing past the last word finishes with pc parked on that word.
    if (w_adv) begin
      if (w_pc_inc >= LEN9) begin
        w_state_nxt = ST_FIN;
      end else begin
        w_state_nxt = ST_RUN;
        w_pc_nxt    = w_pc_inc[7:0];
      end
    end
  end

endmodule

// File: tb/tb_ecc_useq.sv
// Self-checking bench for ecc_useq: directed scenarios plus random
// microprograms checked against an instruction-level reference model.
module tb_ecc_useq;

  localparam logic [7:0] LMASK = 8'b0100_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy0, done0, busy1, done1;
  logic [7:0]  bit0, bit1;
  logic [20:0] rom0 [0:255];
  logic        ready0 = 1'b0, dpdone0 = 1'b0;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [28:0] got_q[$];
  logic [28:0] exp_q[$];

  ecc_useq_if u_if0 ();
  ecc_useq_if u_if1 ();

  assign u_if0.rom_data = rom0[u_if0.rom_addr];
  assign u_if0.dp_ready = ready0;
  assign u_if0.dp_done  = dpdone0;
  assign u_if1.rom_data = '0;
  assign u_if1.dp_ready = 1'b1;
  assign u_if1.dp_done  = 1'b0;

  ecc_useq #(.PROG_LEN(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .bus(u_if0), .bit_idx(bit0)
  );

  ecc_useq #(.PROG_LEN(256)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .bus(u_if1), .bit_idx(bit1)
  );

  function automatic logic [20:0] mkw(input logic [2:0] op, input logic [1:0] m,
                                      input logic [7:0] a, input logic [7:0] b);
    return {op, m, a, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom0[i] = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic pulse_start0;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
  endtask

  // Instruction-level execution of rom0: list of issued commands with bit index.
  task automatic model_run(input int unsigned len);
    int unsigned pc, cnt, head, guard;
    logic [20:0] w;
    logic [2:0]  op;
    bit          jump;
    exp_q.delete();
    pc = 0; cnt = 0; head = 0; guard = 0;
    while (guard < 5000) begin
      guard++;
      w    = rom0[pc];
      op   = w[20:18];
      jump = 1'b0;
      if (op == 3'b010) begin
        if (w[7:0] != 8'd0) begin
          cnt  = w[15:8];
          head = pc + 1;
        end else if (cnt > 1) begin
          cnt  = cnt - 1;
          pc   = head;
          jump = 1'b1;
        end else begin
          cnt = 0;
        end
      end else if (op != 3'b000) begin
        exp_q.push_back({w, (cnt != 0) ? 8'(cnt - 1) : 8'd0});
      end
      if (!jump) begin
        pc++;
        if (pc >= len) break;
      end
    end
  endtask

  // Runs one program on DUT0 from start until busy drops, recording handshakes.
  task automatic run0(input bit rnd, output int unsigned n_done, output bit timeout);
    bit          pending;
    int unsigned cd;
    got_q.delete();
    n_done = 0; pending = 1'b0; cd = 0; timeout = 1'b1;
    pulse_start0;
    for (int c = 0; c < 2000; c++) begin
      dpdone0 = 1'b0;
      if (pending) begin
        if (cd == 0) begin
          dpdone0 = 1'b1;
          pending = 1'b0;
        end else cd--;
      end else if (rnd && $urandom_range(0, 7) == 0) begin
        dpdone0 = 1'b1;
      end
      ready0 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (u_if0.dp_valid && ready0) begin
        got_q.push_back({u_if0.dp_op, u_if0.dp_mode, u_if0.dp_a, u_if0.dp_b, bit0});
        if (LMASK[u_if0.dp_op]) begin
          pending = 1'b1;
          cd = rnd ? $urandom_range(0, 4) : 0;
        end
      end
      if (done0) n_done++;
      if (!busy0) begin
        timeout = 1'b0;
        break;
      end
      tick;
    end
    ready0  = 1'b0;
    dpdone0 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %0b exp 0", busy0); else n_pass++;
    n_total++; if (done0 !== 1'b0) $display("FAIL reset_done: got %0b exp 0", done0); else n_pass++;
    n_total++; if (u_if0.dp_valid !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", u_if0.dp_valid); else n_pass++;
    n_total++; if (u_if0.rom_addr !== 8'd0) $display("FAIL reset_addr: got %0d exp 0", u_if0.rom_addr); else n_pass++;
    n_total++; if (bit0 !== 8'd0) $display("FAIL reset_bit_idx: got %0d exp 0", bit0); else n_pass++;
    n_total++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %0b exp 0", busy1); else n_pass++;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [7:0] ea;
    clear_rom;
    rom0[1] = mkw(3'b100, 2'd1, 8'h11, 8'h22);
    rom0[2] = mkw(3'b101, 2'd2, 8'h33, 8'h44);
    ready0 = 1'b1;
    pulse_start0;
    for (int t = 1; t <= 6; t++) begin
      ea = (t <= 4) ? 8'(t - 1) : ((t == 5) ? 8'd3 : 8'd0);
      n_total++; if (u_if0.dp_valid !== (t == 2 || t == 3)) $display("FAIL basic_valid t=%0d: got %0b", t, u_if0.dp_valid); else n_pass++;
      n_total++; if (done0 !== (t == 5)) $display("FAIL basic_done t=%0d: got %0b", t, done0); else n_pass++;
      n_total++; if (busy0 !== (t <= 5)) $display("FAIL basic_busy t=%0d: got %0b", t, busy0); else n_pass++;
      n_total++; if (u_if0.rom_addr !== ea) $display("FAIL basic_addr t=%0d: got %0d exp %0d", t, u_if0.rom_addr, ea); else n_pass++;
      if (t == 2 || t == 3) begin
        n_total++;
        if ({u_if0.dp_op, u_if0.dp_mode, u_if0.dp_a, u_if0.dp_b} !== rom0[t - 1])
          $display("FAIL basic_fields t=%0d: got %06h exp %06h", t,
                   {u_if0.dp_op, u_if0.dp_mode, u_if0.dp_a, u_if0.dp_b}, rom0[t - 1]);
        else n_pass++;
      end
      tick;
    end
    ready0 = 1'b0;
  endtask

  task automatic test_loop;
    int unsigned nd;
    bit          to;
    clear_rom;
    rom0[0] = mkw(3'b010, 2'd0, 8'd3, 8'd1);
    rom0[1] = mkw(3'b100, 2'd1, 8'h5c, 8'h3e);
    rom0[2] = mkw(3'b010, 2'd0, 8'd0, 8'd0);
    run0(1'b0, nd, to);
    n_total++; if (to !== 1'b0) $display("FAIL loop_timeout: got %0b exp 0", to); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL loop_done_count: got %0d exp 1", nd); else n_pass++;
    n_total++; if (got_q.size() !== 3) $display("FAIL loop_issue_count: got %0d exp 3", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_total++;
      if (got_q[i][7:0] !== 8'(2 - i)) $display("FAIL loop_bit_idx[%0d]: got %0d exp %0d", i, got_q[i][7:0], 2 - i);
      else n_pass++;
    end
  endtask

  task automatic test_long_op;
    int unsigned bad;
    clear_rom;
    rom0[0] = mkw(3'b011, 2'd1, 8'h12, 8'h34);
    ready0 = 1'b1;
    pulse_start0;
    n_total++; if (u_if0.dp_valid !== 1'b1) $display("FAIL long_valid_issue: got %0b exp 1", u_if0.dp_valid); else n_pass++;
    tick;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if0.dp_valid !== 1'b0 || u_if0.rom_addr !== 8'd0 || busy0 !== 1'b1) bad++;
      dpdone0 = (i == 9);
      tick;
    end
    dpdone0 = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL long_hold: got %0d bad cycles exp 0", bad); else n_pass++;
    n_total++; if (u_if0.rom_addr !== 8'd1) $display("FAIL long_advance: got %0d exp 1", u_if0.rom_addr); else n_pass++;
    for (int i = 0; i < 20 && busy0; i++) tick;
    n_total++; if (busy0 !== 1'b0) $display("FAIL long_finish: got busy %0b exp 0", busy0); else n_pass++;
    ready0 = 1'b0;
  endtask

  task automatic test_backpressure;
    int unsigned bad;
    clear_rom;
    rom0[1] = mkw(3'b101, 2'd3, 8'ha5, 8'h5a);
    ready0 = 1'b0;
    pulse_start0;
    tick;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (u_if0.dp_valid !== 1'b1 || u_if0.rom_addr !== 8'd1 ||
          {u_if0.dp_op, u_if0.dp_mode, u_if0.dp_a, u_if0.dp_b} !== rom0[1]) bad++;
      dpdone0 = 1'b1;
      start0  = 1'b1;
      tick;
    end
    dpdone0 = 1'b0;
    start0  = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles exp 0", bad); else n_pass++;
    n_total++; if (u_if0.dp_valid !== 1'b1) $display("FAIL bp_valid_before_ready: got %0b exp 1", u_if0.dp_valid); else n_pass++;
    ready0 = 1'b1;
    tick;
    n_total++; if (u_if0.rom_addr !== 8'd2) $display("FAIL bp_advance: got %0d exp 2", u_if0.rom_addr); else n_pass++;
    tick;
    tick;
    n_total++; if (done0 !== 1'b1) $display("FAIL bp_done: got %0b exp 1", done0); else n_pass++;
    tick;
    tick;
    tick;
    n_total++; if (busy0 !== 1'b0) $display("FAIL bp_no_restart: got busy %0b exp 0", busy0); else n_pass++;
    ready0 = 1'b0;
  endtask

  task automatic test_loop_bounds;
    int unsigned nd;
    bit          to;
    for (int f = 0; f < 2; f++) begin
      clear_rom;
      rom0[0] = mkw(3'b010, 2'd0, 8'(f), 8'h01);
      rom0[1] = mkw(3'b100, 2'd0, 8'h01, 8'h02);
      rom0[2] = mkw(3'b010, 2'd0, 8'h00, 8'h00);
      run0(1'b0, nd, to);
      n_total++; if (got_q.size() !== 1 || nd !== 1 || to !== 1'b0)
        $display("FAIL loop_fa%0d: got issues %0d dones %0d timeout %0b exp 1 1 0", f, got_q.size(), nd, to);
      else n_pass++;
    end
  endtask

  task automatic test_len256;
    int unsigned t_done, wraps;
    logic [7:0]  prev, addr_at_done;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    t_done = 0; wraps = 0; prev = 8'd0; addr_at_done = 8'd0;
    for (int t = 1; t <= 400; t++) begin
      if (u_if1.rom_addr < prev) wraps++;
      prev = u_if1.rom_addr;
      if (done1) begin
        t_done = t;
        addr_at_done = u_if1.rom_addr;
        break;
      end
      tick;
    end
    n_total++; if (t_done !== 257) $display("FAIL len256_done_cycle: got %0d exp 257", t_done); else n_pass++;
    n_total++; if (addr_at_done !== 8'd255) $display("FAIL len256_addr_at_done: got %0d exp 255", addr_at_done); else n_pass++;
    n_total++; if (wraps !== 0) $display("FAIL len256_wrap: got %0d exp 0", wraps); else n_pass++;
    tick;
    n_total++; if (busy1 !== 1'b0 || u_if1.rom_addr !== 8'd0)
      $display("FAIL len256_idle: got busy %0b addr %0d exp 0 0", busy1, u_if1.rom_addr);
    else n_pass++;
  endtask

  task automatic test_abort;
    int unsigned seen;
    clear_rom;
    rom0[0] = mkw(3'b010, 2'd0, 8'd3, 8'd1);
    rom0[1] = mkw(3'b100, 2'd1, 8'h5c, 8'h3e);
    rom0[2] = mkw(3'b010, 2'd0, 8'd0, 8'd0);
    ready0 = 1'b1;
    pulse_start0;
    tick;
    tick;
    tick;
    n_total++; if (bit0 !== 8'd1) $display("FAIL abort_pre_bit_idx: got %0d exp 1", bit0); else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_total++; if ({busy0, done0, u_if0.dp_valid} !== 3'b000)
      $display("FAIL abort_async_flags: got %03b exp 000", {busy0, done0, u_if0.dp_valid});
    else n_pass++;
    n_total++; if (u_if0.rom_addr !== 8'd0 || bit0 !== 8'd0)
      $display("FAIL abort_async_regs: got addr %0d bit %0d exp 0 0", u_if0.rom_addr, bit0);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done0 || busy0) seen++;
      tick;
    end
    n_total++; if (seen !== 0) $display("FAIL abort_no_done: got %0d active cycles exp 0", seen); else n_pass++;
    ready0 = 1'b0;
  endtask

  task automatic test_random;
    int unsigned nd;
    bit          to;
    logic [2:0]  op;
    for (int p = 0; p < 40; p++) begin
      do_reset;
      clear_rom;
      for (int i = 0; i < 4; i++) begin
        op = 3'($urandom_range(0, 7));
        if (op == 3'b010)
          rom0[i] = mkw(op, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'd0);
        else
          rom0[i] = mkw(op, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)));
      end
      model_run(4);
      run0(1'b1, nd, to);
      n_total++; if (to !== 1'b0 || nd !== 1)
        $display("FAIL rand%0d_done: got timeout %0b dones %0d exp 0 1", p, to, nd);
      else n_pass++;
      n_total++; if (got_q.size() !== exp_q.size())
        $display("FAIL rand%0d_count: got %0d exp %0d", p, got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rand%0d_cmd[%0d]: got %08h exp %08h", p, i, got_q[i], exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom;
    test_reset;
    test_basic;
    test_loop;
    test_long_op;
    test_backpressure;
    test_loop_bounds;
    test_len256;
    test_abort;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ecc_useq.md
Name: ecc_useq

Overview:
- Microprogram sequencer for the ECC point-arithmetic engine.
- Drives the 8-bit address of the 21-bit microcode ROM and decodes each returned word.
- Runs hardware loops, for example one iteration per scalar bit, and exposes the current bit index.
- Issues datapath operations over a valid/ready handshake and stalls on multi-cycle field operations until the datapath reports completion.
- Sits between the top-level start/done control and the field-arithmetic datapath.

Parameters:
- PROG_LEN, 70, number of ROM words executed; legal range 1..256; execution ends when pc would pass PROG_LEN-1.
- LONG_OP_MASK, 8'b0100_1000, bit k set means opcode k is multi-cycle and waits for dp_done. Default marks opcodes 011 and 110.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution at address 0. Ignored while busy.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the program completes.
- rom_addr  out  8  microcode address; equals pc.
- rom_data  in  21  combinational ROM word for rom_addr. Fields: [20:18] op, [17:16] mode, [15:8] fa, [7:0] fb.
- dp_valid  out  1  datapath command valid.
- dp_op  out  3  opcode field, passed through from rom_data.
- dp_mode  out  2  mode field, passed through from rom_data.
- dp_a  out  8  fa field, passed through from rom_data.
- dp_b  out  8  fb field, passed through from rom_data.
- dp_ready  in  1  datapath accepts the command this cycle.
- dp_done  in  1  one-cycle pulse; the current long op has finished.
- bit_idx  out  8  current loop iteration index, counting down to 0.

Behaviour:
- Reset values: state IDLE, pc 0, loop_cnt 0, loop_head 0, busy 0, done 0, dp_valid 0, bit_idx 0.
- dp_op, dp_mode, dp_a and dp_b are don't-care while dp_valid is 0.
- rst is asserted asynchronously and released synchronously. Reset mid-program aborts immediately; no done pulse is produced.
- States: IDLE, RUN, WAIT, FIN.
- IDLE:
  - start=1 moves to RUN with pc=0 and busy=1 on the next cycle.
  - dp_done is ignored.
- RUN decodes rom_data combinationally; one instruction is evaluated per cycle.
  - op 000 (NOP): pc advances by 1.
  - op 010 with fb != 0 (LOOP_SET): loop_cnt <= fa, loop_head <= pc+1, pc advances by 1.
  - op 010 with fb == 0 (LOOP_END):
    - If loop_cnt > 1: loop_cnt decrements and pc <= loop_head.
    - Otherwise: loop_cnt <= 0 and pc advances by 1.
    - Net effect: the body runs max(fa,1) times.
  - Loops do not nest. A LOOP_SET inside a loop body overwrites loop_cnt and loop_head.
  - Any other op (001, 011, 100, 101, 110, 111) is a datapath command:
    - dp_valid=1 combinationally, with dp_op/dp_mode/dp_a/dp_b taken from rom_data.
    - While dp_ready=0, pc holds and the command stays stable.
    - On the dp_ready=1 cycle, if LONG_OP_MASK[op] is set, go to WAIT with pc unchanged; otherwise pc advances by 1.
- WAIT:
  - dp_valid=0.
  - On dp_done=1, pc advances by 1 and the state returns to RUN.
  - dp_done in any other state is ignored.
- pc advance rule:
  - Next pc is computed 9 bits wide.
  - If next pc >= PROG_LEN, go to FIN instead of RUN; pc holds its last value.
  - This includes PROG_LEN=256, where the next pc would be 256.
  - Jump targets (loop_head) are not range checked; the loop_head of the last word equals PROG_LEN and terminates at LOOP_END fall-through only.
- FIN: done=1 for exactly one cycle, then IDLE with busy=0 and pc=0.
- bit_idx = loop_cnt-1 when loop_cnt != 0; otherwise 0.
- start arriving in the FIN cycle is ignored.
- Throughput: one instruction per cycle when there are no stalls. Latency from start to the first dp_valid is 1 cycle plus any leading NOP/LOOP words.

Decomposition:
- Package ecc_useq_pkg holds:
  - Opcode localparams: OP_NOP=3'b000, OP_LOOP=3'b010, plus datapath opcode names.
  - Field bit positions.
  - State encoding.
  - Default LONG_OP_MASK.
- One sub-module, ecc_loop_ctr: holds loop_cnt and loop_head, with set and end inputs, and outputs taken and bit_idx.
- All other logic lives in ecc_useq.

Test Plan:
- Basic run. Stimulus: PROG_LEN=4, ROM {NOP, 100 cmd, 101 cmd, NOP}, dp_ready tied 1. Response: dp_valid high at pc 1 and 2 with fields matching the ROM; done 5 cycles after start; busy clears in the same cycle done falls.
- Loop. Stimulus: word0 LOOP_SET fa=3 fb=1, word1 100 cmd, word2 LOOP_END, PROG_LEN=3. Response: cmd issued 3 times; bit_idx reads 2,1,0 at each issue; single done.
- Long op. Stimulus: op 011 with dp_ready=1; dp_done delivered 10 cycles later. Response: dp_valid is high for 1 cycle only; pc holds for 10 cycles; pc advances in the cycle after dp_done.
- Backpressure. Stimulus: dp_ready=0 for 5 cycles on op 101. Response: dp_valid and all fields held stable; pc unchanged; advance on the first ready.
- Boundaries. Stimulus: LOOP_SET fa=0 and fa=1. Response: body runs once in both cases. Stimulus: PROG_LEN=256 with all NOPs. Response: done after 256 RUN cycles; no wrap to address 0.
- Abort/ignore. Stimulus: assert rst mid-loop. Response: all outputs return to reset values asynchronously; no done pulse. Stimulus: start pulse while busy. Response: no effect. Stimulus: spurious dp_done in RUN. Response: ignored.
